// File: rtl/div_ctrl_pkg.sv
// Shared divide-sequencer definitions: state encoding and default operand width.
package div_ctrl_pkg;

  localparam int unsigned DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } div_state_t;

endpackage

// File: rtl/div_ctrl_if.sv
// E-stage divide request/response bundle between the pipeline and div_ctrl.
interface div_ctrl_if import div_ctrl_pkg::*; #(
  parameter int unsigned WIDTH = DIV_WIDTH
) ();

  logic             start;
  logic             signed_div;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             cancel;
  logic             stall;
  logic             result_valid;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  // Pipeline side: issues the request, consumes stall and the HI/LO result.
  modport master (
    output start, signed_div, opa, opb, cancel,
    input  stall, result_valid, hi, lo
  );

  // Divider side.
  modport slave (
    input  start, signed_div, opa, opb, cancel,
    output stall, result_valid, hi, lo
  );

endinterface

// File: rtl/div_ctrl_iter.sv
// One radix-2 restoring step: shift in the next dividend bit, trial-subtract the divisor.
module div_iter import div_ctrl_pkg::*; #(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   remIn,
  input  logic [WIDTH-1:0] divisor,
  input  logic             dividendBit,
  output logic [WIDTH:0]   remOut,
  output logic             qBit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  // Extra top bit on the trial difference gives the borrow/sign for the restore decision.
  always_comb begin
    shifted = {remIn, dividendBit};
    diff    = shifted - {2'b00, divisor};
    qBit    = ~diff[WIDTH+1];
    remOut  = qBit ? diff[WIDTH:0] : shifted[WIDTH:0];
  end

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle DIV/DIVU sequencer for the E stage: stalls the pipe, runs WIDTH
// restoring steps, applies the sign fix-up and presents HI/LO with a one-cycle valid.
module div_ctrl import div_ctrl_pkg::*; #(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic     clk,
  input  logic     resetn,
  div_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  div_state_t state;
  div_state_t stateNext;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] dvd;        // dividend magnitude, quotient bits shift in from the LSB
  logic [WIDTH-1:0] dsr;        // divisor magnitude
  logic [WIDTH:0]   rem;        // partial remainder
  logic             negQ;
  logic             negR;
  logic [WIDTH-1:0] hiReg;
  logic [WIDTH-1:0] loReg;
  logic [WIDTH-1:0] hiPrev;
  logic [WIDTH-1:0] loPrev;

  logic             accept;
  logic             divZero;
  logic             lastStep;
  logic             opaNeg;
  logic             opbNeg;
  logic [WIDTH-1:0] absA;
  logic [WIDTH-1:0] absB;
  logic [WIDTH:0]   stepRem;
  logic             stepQ;
  logic [WIDTH-1:0] magQ;
  logic [WIDTH-1:0] magR;
  logic [WIDTH-1:0] finQ;
  logic [WIDTH-1:0] finR;

  div_iter #(.WIDTH(WIDTH)) u_iter (
    .remIn       (rem),
    .divisor     (dsr),
    .dividendBit (dvd[WIDTH-1]),
    .remOut      (stepRem),
    .qBit        (stepQ)
  );

  // Request decode and operand magnitudes; 0x80..0 negates to itself, which is its exact magnitude.
  always_comb begin
    accept   = bus.start & ~bus.cancel;
    divZero  = (bus.opb == '0);
    lastStep = (cnt == LAST_CNT);
    opaNeg   = bus.signed_div & bus.opa[WIDTH-1];
    opbNeg   = bus.signed_div & bus.opb[WIDTH-1];
    absA     = opaNeg ? (~bus.opa + WIDTH'(1)) : bus.opa;
    absB     = opbNeg ? (~bus.opb + WIDTH'(1)) : bus.opb;
  end

  // Final result from the last step, with the signed fix-up applied.
  always_comb begin
    magQ = {dvd[WIDTH-2:0], stepQ};
    magR = stepRem[WIDTH-1:0];
    finQ = negQ ? (~magQ + WIDTH'(1)) : magQ;
    finR = negR ? (~magR + WIDTH'(1)) : magR;
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic; cancel returns to IDLE from any state.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (accept) begin
          stateNext = divZero ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (bus.cancel) begin
          stateNext = IDLE;
        end else if (lastStep) begin
          stateNext = DONE;
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // FSM outputs: stall tracks the held request combinationally so it rises with start.
  always_comb begin
    bus.stall        = accept & (state != DONE);
    bus.result_valid = (state == DONE) & ~bus.cancel;
  end

  // Datapath: operand latch, iteration, and HI/LO result registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt    <= '0;
      dvd    <= '0;
      dsr    <= '0;
      rem    <= '0;
      negQ   <= 1'b0;
      negR   <= 1'b0;
      hiReg  <= '0;
      loReg  <= '0;
      hiPrev <= '0;
      loPrev <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (divZero) begin
              hiPrev <= hiReg;
              loPrev <= loReg;
              hiReg  <= bus.opa;
              loReg  <= '1;
            end else begin
              dvd  <= absA;
              dsr  <= absB;
              rem  <= '0;
              cnt  <= '0;
              negQ <= opaNeg ^ opbNeg;
              negR <= opaNeg;
            end
          end
        end
        BUSY: begin
          if (!bus.cancel) begin
            dvd <= {dvd[WIDTH-2:0], stepQ};
            rem <= stepRem;
            cnt <= cnt + CNT_W'(1);
            if (lastStep) begin
              hiPrev <= hiReg;
              loPrev <= loReg;
              hiReg  <= finR;
              loReg  <= finQ;
            end
          end
        end
        DONE: begin
          // A flush landing on the result cycle withdraws the result it just loaded.
          if (bus.cancel) begin
            hiReg <= hiPrev;
            loReg <= loPrev;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.hi = hiReg;
  assign bus.lo = loReg;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl: stimulus pushes expected HI/LO into a queue, a
// monitor pops and compares on every result_valid pulse.
module tb_div_ctrl;
  import div_ctrl_pkg::*;

  localparam int unsigned W = DIV_WIDTH;

  logic clk = 1'b0;
  logic resetn;

  always #5 clk = ~clk;

  div_ctrl_if #(.WIDTH(W)) bus ();

  div_ctrl #(.WIDTH(W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int passCnt  = 0;
  int totalCnt = 0;
  logic [2*W-1:0] expQ[$];
  logic [W-1:0]   lastHi = '0;
  logic [W-1:0]   lastLo = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    totalCnt++;
    if (act === exp) begin
      passCnt++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every result pulse must match the oldest outstanding expectation.
  initial begin
    logic [2*W-1:0] e;
    forever begin
      @(negedge clk);
      if (resetn === 1'b1 && bus.result_valid === 1'b1) begin
        if (expQ.size() == 0) begin
          totalCnt++;
          $display("FAIL unexpected_result: hi=0x%0h lo=0x%0h at %0t", bus.hi, bus.lo, $time);
        end else begin
          e = expQ.pop_front();
          check("result_hi", 64'(bus.hi), 64'(e[2*W-1:W]));
          check("result_lo", 64'(bus.lo), 64'(e[W-1:0]));
        end
      end
    end
  end

  // Issue one divide and hold start until stall falls; start is left high for back-to-back use.
  task automatic doDiv(input string name, input logic sd, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] expHi, input logic [W-1:0] expLo, input int expStall);
    int  n;
    bit  fell;
    @(posedge clk);
    #1;
    bus.start      = 1'b1;
    bus.signed_div = sd;
    bus.opa        = a;
    bus.opb        = b;
    bus.cancel     = 1'b0;
    expQ.push_back({expHi, expLo});
    n    = 0;
    fell = 1'b0;
    for (int i = 0; i < 100 && !fell; i++) begin
      @(negedge clk);
      if (bus.stall === 1'b1) n++;
      else fell = 1'b1;
    end
    if (!fell) begin
      totalCnt++;
      $display("FAIL %s_timeout: stall still high after 100 cycles", name);
    end
    check({name, "_stall_cycles"}, 64'(n), 64'(expStall));
    check({name, "_valid_when_stall_falls"}, 64'(bus.result_valid), 64'(1));
    lastHi = expHi;
    lastLo = expLo;
  endtask

  task automatic releaseE();
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn         = 1'b0;
    bus.start      = 1'b0;
    bus.cancel     = 1'b0;
    bus.signed_div = 1'b0;
    bus.opa        = '0;
    bus.opb        = '0;

    #12;
    check("reset_stall", 64'(bus.stall), 64'(0));
    check("reset_valid", 64'(bus.result_valid), 64'(0));
    check("reset_hi", 64'(bus.hi), 64'(0));
    check("reset_lo", 64'(bus.lo), 64'(0));
    @(negedge clk);
    resetn = 1'b1;

    doDiv("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, W + 1);
    releaseE();

    // Back-to-back signed divides with start held continuously.
    doDiv("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, W + 1);
    doDiv("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, W + 1);
    releaseE();

    doDiv("div_by_zero", 1'b1, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 1);
    doDiv("div_by_zero_neg", 1'b1, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1);
    releaseE();

    doDiv("div_overflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, W + 1);
    doDiv("divu_8000_ffff", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, W + 1);
    doDiv("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, W + 1);
    doDiv("divu_max_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1, W + 1);
    doDiv("divu_5_10", 1'b0, 32'd5, 32'd10, 32'd5, 32'd0, W + 1);
    doDiv("div_min_2", 1'b1, 32'h8000_0000, 32'd2, 32'd0, 32'hC000_0000, W + 1);
    doDiv("div_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd14, W + 1);
    releaseE();

    // start and cancel in the same IDLE cycle must not launch a divide.
    @(posedge clk);
    #1;
    bus.start      = 1'b1;
    bus.cancel     = 1'b1;
    bus.signed_div = 1'b0;
    bus.opa        = 32'd100;
    bus.opb        = 32'd7;
    @(negedge clk);
    check("start_cancel_stall", 64'(bus.stall), 64'(0));
    releaseE();
    repeat (40) @(negedge clk);

    // Cancel at BUSY cycle 10: no result, HI/LO untouched, next divide starts cleanly.
    @(posedge clk);
    #1;
    bus.start      = 1'b1;
    bus.signed_div = 1'b0;
    bus.opa        = 32'd100;
    bus.opb        = 32'd7;
    repeat (10) @(posedge clk);
    #1;
    bus.cancel = 1'b1;
    @(negedge clk);
    check("cancel_stall", 64'(bus.stall), 64'(0));
    check("cancel_valid", 64'(bus.result_valid), 64'(0));
    releaseE();
    @(negedge clk);
    check("cancel_hi_held", 64'(bus.hi), 64'(lastHi));
    check("cancel_lo_held", 64'(bus.lo), 64'(lastLo));
    doDiv("divu_9_3_after_cancel", 1'b0, 32'd9, 32'd3, 32'd0, 32'd3, W + 1);
    releaseE();

    // Reset in the middle of BUSY clears everything immediately.
    @(posedge clk);
    #1;
    bus.start      = 1'b1;
    bus.signed_div = 1'b0;
    bus.opa        = 32'd100;
    bus.opb        = 32'd7;
    repeat (5) @(posedge clk);
    #1;
    resetn    = 1'b0;
    bus.start = 1'b0;
    #1;
    check("midreset_stall", 64'(bus.stall), 64'(0));
    check("midreset_valid", 64'(bus.result_valid), 64'(0));
    check("midreset_hi", 64'(bus.hi), 64'(0));
    check("midreset_lo", 64'(bus.lo), 64'(0));
    @(negedge clk);
    resetn = 1'b1;
    doDiv("divu_100_7_after_reset", 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, W + 1);
    releaseE();

    repeat (5) @(negedge clk);
    check("all_results_seen", 64'(expQ.size()), 64'(0));

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Multi-cycle divide sequencer for the execute stage of the 5-stage MIPS pipeline. Accepts a DIV/DIVU request from E and runs a radix-2 restoring divider for WIDTH iterations. It holds the pipeline through the stall output, which feeds the hazard unit's E-stage divide-stall input. It returns quotient and remainder for the HI/LO write and aborts cleanly when an older instruction in M raises an exception.

## Interface

Parameters:
- WIDTH, 32, operand width; iteration count equals WIDTH.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  a valid DIV/DIVU is in E; held high for as long as the instruction sits in E.
- signed_div  in  1  1 selects DIV (signed), 0 selects DIVU.
- opa  in  WIDTH  dividend (rs value after forwarding).
- opb  in  WIDTH  divisor (rt value after forwarding).
- cancel  in  1  M-stage exception flush; kills any divide in flight.
- stall  out  1  divide-stall request to the hazard unit.
- result_valid  out  1  one-cycle pulse; hi/lo are valid for the HI/LO write.
- hi  out  WIDTH  remainder.
- lo  out  WIDTH  quotient.

## Operation

- FSM states: IDLE, BUSY, DONE.
- IDLE, start=1, cancel=0, opb!=0:
  - latch operand magnitudes, signs and signed_div;
  - clear the iteration counter;
  - go to BUSY.
- IDLE, start=1, cancel=0, opb==0: go to DONE with lo = all ones and hi = opa (raw, unsigned interpretation, no sign fix-up).
- BUSY: each cycle, one restoring step:
  - shift partial remainder left by 1 and bring in the next dividend MSB;
  - subtract |divisor|; on a non-negative result keep the difference and set quotient bit 1;
  - increment the counter;
  - after the step with count == WIDTH-1, go to DONE.
- DONE: drive result_valid=1 and register the final hi/lo; go to IDLE. start is ignored in DONE, so the held request cannot retrigger.
- Signed fix-up:
  - quotient negative when sign(opa) xor sign(opb);
  - remainder takes the sign of opa;
  - apply two's-complement negation to the magnitude results.
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (wraps, no trap).
- stall = start & ~cancel & (state != DONE).
- cancel has priority in every state: next state IDLE, no result_valid, hi/lo keep their previous values.
- Arithmetic widths:
  - partial remainder is WIDTH+1 bits;
  - counter is $clog2(WIDTH) bits;
  - magnitude of 0x80000000 is represented exactly as unsigned.

## Timing

- Reset values (asynchronous, while resetn=0): state=IDLE, counter=0, stall=0, result_valid=0, hi=0, lo=0.
- stall is combinational from start, cancel and state, so it asserts in the same cycle start first rises.
- Normal divide:
  - start seen in IDLE at cycle 0;
  - BUSY for cycles 1..WIDTH;
  - DONE at cycle WIDTH+1, where stall=0 and result_valid=1;
  - stall is high for WIDTH+1 cycles, so the instruction leaves E at the end of cycle WIDTH+1.
- Divide by zero: stall is high for cycle 0 only; DONE at cycle 1.
- hi/lo are registered, valid from DONE onward, and held until the next DONE.
- start dropping while BUSY (not accompanied by cancel): the divide still completes to DONE and IDLE; the result pulse is produced but unused.
- cancel and start in the same IDLE cycle: stay IDLE, stall=0.
- Back-to-back divides: the second start is accepted in the IDLE cycle immediately after DONE.
- resetn low mid-BUSY: immediate IDLE, all outputs 0; no partial result is kept.

## Structure

- Shared package (cpu defines):
  - div_state_t encoding: IDLE=2'b00, BUSY=2'b01, DONE=2'b10;
  - DIV_WIDTH=32.
- One natural sub-module, div_iter: the combinational single restoring step.
  - inputs: partial remainder, divisor magnitude, next dividend bit;
  - outputs: new remainder, quotient bit.
- div_ctrl owns the FSM, counter, operand and sign registers, fix-up and output registers.

## Test plan

- DIVU 100/7, start held until stall falls -> stall high for exactly 33 cycles; result_valid single pulse at cycle 33; lo=14, hi=2.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 7/-2 -> lo=0xFFFFFFFD, hi=1.
- DIV 0x1234/0 -> stall high for 1 cycle; DONE at cycle 1; lo=0xFFFFFFFF, hi=0x1234.
- DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU with same operands -> lo=0, hi=0x80000000.
- Start 100/7, assert cancel at BUSY cycle 10 -> stall low that cycle; IDLE next cycle; no result_valid; hi/lo unchanged. A new start 9/3 the following cycle -> lo=3, hi=0 after 33 cycles.
- resetn pulsed low at BUSY cycle 5 -> stall, result_valid, hi, lo all 0 immediately; the next start completes normally.
